// File: rtl/freq_gate_counter_pkg.sv
// -----------------------------------------------------------------------------
// freq_gate_counter_pkg
//   Shared definitions for the frequency-meter gate counter: FSM state
//   encodings and default build constants.
// -----------------------------------------------------------------------------
package freq_gate_counter_pkg;

  // Gate controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // 1 s gate at 50 MHz
  localparam int unsigned DEF_GATE_CYCLES = 50_000_000;
  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/freq_gate_counter_edge_sync.sv
// -----------------------------------------------------------------------------
// freq_gate_counter_edge_sync
//   Brings the asynchronous measured signal into the clk domain and produces a
//   one-cycle registered pulse on each rising edge.
//   Latency from sig_in rise to edge_pulse high is SYNC_STAGES+1 clocks.
// Ports
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   sig_in     in  measured signal, asynchronous to clk
//   edge_pulse out one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module freq_gate_counter_edge_sync
  import freq_gate_counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;
  logic                   edge_p2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
      edge_p2 <= 1'b0;
    end else begin
      // stage p0: metastability chain, bit 0 is the first flop
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_in};
      // stage p1: previous synchronized level
      prev_p1 <= sync_p0[SYNC_STAGES-1];
      // stage p2: registered rising-edge pulse
      edge_p2 <= sync_p0[SYNC_STAGES-1] & ~prev_p1;
    end
  end

  assign edge_pulse = edge_p2;

endmodule

// File: rtl/freq_gate_counter.sv
// -----------------------------------------------------------------------------
// freq_gate_counter
//   Gated edge counter for the frequency meter. On start it opens a gate of
//   exactly GATE_CYCLES clocks, counts synchronized rising edges of sig_in
//   (saturating), then latches the count and raises freq_en until the CPU
//   acknowledges with clr_ack.
// Ports
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   sig_in     in  measured signal, asynchronous to clk
//   start      in  begins a measurement when idle
//   clr_ack    in  releases the held result
//   freq_en    out result valid; count_out stable while high
//   count_out  out edge count of the last completed gate
//   busy       out high while the gate is open
//   overflow   out count saturated during the last gate
// -----------------------------------------------------------------------------
module freq_gate_counter
  import freq_gate_counter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             clr_ack,
  output logic             freq_en,
  output logic [CNT_W-1:0] count_out,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned TMR_W = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               ovf;
  logic               ovf_nxt;
  logic               edge_pulse;

  // Saturating increment: holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  freq_gate_counter_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .sig_in     (sig_in),
    .edge_pulse (edge_pulse)
  );

  // Count including the current cycle's edge, so the final gate cycle is
  // folded into the latched result.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (edge_pulse) begin
      cnt_nxt = sat_inc(cnt);
      if (cnt == '1) ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      freq_en   <= 1'b0;
      count_out <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_GATE;
            timer <= TMR_LOAD;
            cnt   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_GATE: begin
          cnt <= cnt_nxt;
          ovf <= ovf_nxt;
          if (timer == '0) begin
            state     <= ST_HOLD;
            count_out <= cnt_nxt;
            overflow  <= ovf_nxt;
            freq_en   <= 1'b1;
            busy      <= 1'b0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        ST_HOLD: begin
          // start is deliberately not looked at here; ack returns to IDLE only
          if (clr_ack) begin
            state   <= ST_IDLE;
            freq_en <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          freq_en <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
